mem_arbiter: RTL and testbench

- Shares one single-port external memory between the CPU instruction-fetch port and the data port, which today drive the memory pins independently.
- Accepts level requests from the fetch unit and the control unit, and sequences one memory access at a time with a ready handshake.
- Returns read data and an ack pulse to the requester that was served.
- Data accesses have priority; a starvation counter guarantees fetch progress.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_grant.sv | 39 +++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ST_W     = 2;
  localparam int unsigned STARVE_W = 4;

  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_ACCESS = 2'd1;
  localparam logic [ST_W-1:0] ST_RESP   = 2'd2;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant decision between fetch and data, with a starvation counter that
// forces a fetch grant after STARVE_MAX consecutive data wins.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic grant_en,
  output logic grant_valid,
  output logic grant_owner
);

  logic [STARVE_W-1:0] starve_cnt;
  logic                starved;

  always_comb begin
    starved     = (starve_cnt == STARVE_W'(STARVE_MAX));
    grant_valid = grant_en & (if_req | d_req);
    grant_owner = (d_req && !(if_req && starved)) ? OWN_DATA : OWN_FETCH;
  end

  // Counts data wins while fetch waits; any fetch grant clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_valid) begin
      if (grant_owner == OWN_FETCH) begin
        starve_cnt <= '0;
      end else if (if_req && !starved) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data ports,
// one access at a time: IDLE (arbitrate) -> ACCESS (wait mem_ready) -> RESP (ack).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              owner
);

  logic [ST_W-1:0]   state, state_d;
  logic              owner_d;
  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              if_ack_d, d_ack_d, busy_d;
  logic [DATA_W-1:0] if_rdata_d, d_rdata_d;
  logic              grant_en, grant_valid, grant_owner;

  mem_arb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .d_req       (d_req),
    .grant_en    (grant_en),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // The mem_* registers double as the latched request; they hold through ACCESS.
  always_comb begin
    state_d     = state;
    owner_d     = owner;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;
    grant_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        grant_en = 1'b1;
        if (grant_valid) begin
          state_d  = ST_ACCESS;
          owner_d  = grant_owner;
          mem_en_d = 1'b1;
          if (grant_owner == OWN_DATA) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            mem_addr_d  = if_addr;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ready) begin
          state_d = ST_RESP;
          if (owner == OWN_DATA) begin
            d_ack_d = 1'b1;
            if (!mem_we) d_rdata_d = mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          mem_en_d    = 1'b1;
          mem_we_d    = mem_we;
          mem_addr_d  = mem_addr;
          mem_wdata_d = mem_wdata;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_FETCH;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_ack    <= if_ack_d;
      d_ack     <= d_ack_d;
      if_rdata  <= if_rdata_d;
      d_rdata   <= d_rdata_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected accesses are queued as requests
// are issued and compared at access start and at the ack.
module tb_mem_arbiter;

  localparam int unsigned STARVE_MAX = 4;

  typedef struct packed {
    logic        own;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [3:0]  starve;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready = 1'b0;
  logic        busy, owner;

  int checks = 0;
  int failures = 0;

  exp_t sb[$];
  exp_t mon_e;
  logic [15:0] m_if_rdata = '0, m_d_rdata = '0;
  logic [3:0]  m_starve = '0;

  logic        fixed_en = 1'b0;
  logic [15:0] fixed_val = '0;
  logic        stall = 1'b0, force_ready = 1'b0;
  int          wait_states = 0, en_cnt = 0;
  int          if_left = 0, d_left = 0;
  int          if_acks = 0, d_acks = 0;
  logic        in_acc = 1'b0, we_any = 1'b0, last_we_any = 1'b0;
  int          en_len = 0, last_en_len = 0;
  int          base;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rd_val(input logic [15:0] a);
    return fixed_en ? fixed_val : (a ^ 16'hC3C3);
  endfunction

  assign mem_rdata = rd_val(mem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Queue one expected access in grant order and advance the reference model.
  task automatic push(input logic own, input logic we, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic if_wait);
    exp_t e;
    e.own   = own;
    e.we    = own ? we : 1'b0;
    e.addr  = addr;
    e.wdata = own ? wdata : 16'h0;
    if (own) begin
      if (if_wait && m_starve != 4'(STARVE_MAX)) m_starve = m_starve + 4'd1;
      if (!we) m_d_rdata = rd_val(addr);
      e.rdata = m_d_rdata;
    end else begin
      m_starve   = '0;
      m_if_rdata = rd_val(addr);
      e.rdata    = m_if_rdata;
    end
    e.starve = m_starve;
    sb.push_back(e);
  endtask

  task automatic req_data(input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input int reps);
    d_we = we; d_addr = addr; d_wdata = wdata; d_left = reps; d_req = 1'b1;
  endtask

  task automatic req_fetch(input logic [15:0] addr, input int reps);
    if_addr = addr; if_left = reps; if_req = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 300 && !(sb.size() == 0 && !busy && !if_req && !d_req));
    if (n >= 300) check("idle_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  // Memory responder: mem_ready after wait_states extra ACCESS cycles.
  always @(negedge clk) begin
    if (!mem_en) en_cnt = 0;
    if (force_ready) mem_ready = 1'b1;
    else if (mem_en && !stall) begin
      mem_ready = (en_cnt == wait_states);
      en_cnt++;
    end else mem_ready = 1'b0;
  end

  // Scoreboard monitor and requester model (drops req after its last ack).
  always @(negedge clk) begin
    if (mem_we && !mem_en) check("we_without_en", 32'(mem_we), 32'd0);
    if (mem_en) begin
      if (!in_acc) begin
        in_acc = 1'b1; en_len = 0; we_any = 1'b0;
        if (sb.size() == 0) check("unexp_access", 32'(mem_en), 32'd0);
        else begin
          mon_e = sb[0];
          check("acc_owner", 32'(owner), 32'(mon_e.own));
          check("acc_addr", 32'(mem_addr), 32'(mon_e.addr));
          check("acc_we", 32'(mem_we), 32'(mon_e.we));
          check("acc_wdata", 32'(mem_wdata), 32'(mon_e.wdata));
          check("acc_starve", 32'(dut.u_grant.starve_cnt), 32'(mon_e.starve));
        end
      end
      en_len++;
      we_any = we_any | mem_we;
    end else in_acc = 1'b0;
    if (if_ack || d_ack) begin
      if (if_ack) if_acks++;
      if (d_ack) d_acks++;
      last_en_len = en_len;
      last_we_any = we_any;
      if (sb.size() == 0) check("unexp_ack", 32'({if_ack, d_ack}), 32'd0);
      else begin
        mon_e = sb.pop_front();
        check("ack_sel", 32'({if_ack, d_ack}), mon_e.own ? 32'd1 : 32'd2);
        if (mon_e.own) check("d_rdata", 32'(d_rdata), 32'(mon_e.rdata));
        else check("if_rdata", 32'(if_rdata), 32'(mon_e.rdata));
      end
      if (if_ack && if_left > 0) begin if_left--; if (if_left == 0) if_req = 1'b0; end
      if (d_ack && d_left > 0) begin d_left--; if (d_left == 0) d_req = 1'b0; end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #1;
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_if_ack", 32'(if_ack), 0);
    check("rst_d_ack", 32'(d_ack), 0);
    check("rst_if_rdata", 32'(if_rdata), 0);
    check("rst_d_rdata", 32'(d_rdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_starve", 32'(dut.u_grant.starve_cnt), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-access aborts without ack
    fixed_en = 1'b1; fixed_val = 16'hBEEF; stall = 1'b1;
    base = d_acks;
    push(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);
    req_data(1'b0, 16'h0010, 16'h0, 1);
    repeat (3) @(negedge clk);
    check("pre_rst_mem_en", 32'(mem_en), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_mem_en", 32'(mem_en), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_d_ack", 32'(d_ack), 0);
    d_req = 1'b0; d_left = 0; stall = 1'b0;
    sb.delete();
    m_if_rdata = '0; m_d_rdata = '0; m_starve = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_no_d_ack", 32'(d_acks - base), 0);

    // Rerun: minimum two-cycle latency
    push(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);
    req_data(1'b0, 16'h0010, 16'h0, 1);
    @(negedge clk);
    check("lat_mem_en", 32'(mem_en), 1);
    check("lat_early_ack", 32'(d_ack), 0);
    @(negedge clk);
    check("lat_d_ack", 32'(d_ack), 1);
    check("lat_d_rdata", 32'(d_rdata), 32'h0000BEEF);
    wait_idle();

    // Fetch read with wait states
    fixed_val = 16'h1234; wait_states = 2;
    base = if_acks;
    push(1'b0, 1'b0, 16'h0100, 16'h0, 1'b0);
    req_fetch(16'h0100, 1);
    wait_idle();
    check("fetch_en_len", 32'(last_en_len), 3);
    check("fetch_we_seen", 32'(last_we_any), 0);
    check("fetch_ack_pulses", 32'(if_acks - base), 1);
    check("fetch_if_rdata", 32'(if_rdata), 32'h00001234);
    wait_states = 0;

    // Data write leaves d_rdata untouched
    fixed_val = 16'h1111;
    push(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0);
    req_data(1'b0, 16'h0020, 16'h0, 1);
    wait_idle();
    base = d_acks;
    push(1'b1, 1'b1, 16'h8000, 16'hA5A5, 1'b0);
    req_data(1'b1, 16'h8000, 16'hA5A5, 1);
    wait_idle();
    check("wr_we_seen", 32'(last_we_any), 1);
    check("wr_ack_pulses", 32'(d_acks - base), 1);
    check("wr_d_rdata", 32'(d_rdata), 32'h00001111);
    d_we = 1'b0;

    // Simultaneous requests: data first, then fetch
    fixed_en = 1'b0;
    push(1'b1, 1'b0, 16'h0400, 16'h0, 1'b1);
    push(1'b0, 1'b0, 16'h0500, 16'h0, 1'b0);
    req_data(1'b0, 16'h0400, 16'h0, 1);
    req_fetch(16'h0500, 1);
    wait_idle();
    check("simul_owner_last", 32'(owner), 0);

    // Starvation: four data grants, then fetch forced, then data again
    for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 16'h0200, 16'h0077, 1'b1);
    push(1'b0, 1'b0, 16'h0300, 16'h0, 1'b0);
    for (int i = 0; i < 2; i++) push(1'b1, 1'b0, 16'h0200, 16'h0077, 1'b0);
    base = if_acks;
    req_data(1'b0, 16'h0200, 16'h0077, 6);
    req_fetch(16'h0300, 1);
    wait_idle();
    check("starve_fetch_acks", 32'(if_acks - base), 1);
    check("starve_cnt_final", 32'(dut.u_grant.starve_cnt), 0);

    // Stray mem_ready in IDLE and RESP
    force_ready = 1'b1;
    base = if_acks + d_acks;
    repeat (3) @(negedge clk);
    check("stray_idle_busy", 32'(busy), 0);
    check("stray_idle_en", 32'(mem_en), 0);
    check("stray_idle_acks", 32'(if_acks + d_acks - base), 0);
    push(1'b0, 1'b0, 16'h0600, 16'h0, 1'b0);
    req_fetch(16'h0600, 1);
    wait_idle();
    repeat (2) @(negedge clk);
    check("stray_acks", 32'(if_acks + d_acks - base), 1);
    check("stray_en_len", 32'(last_en_len), 1);
    check("stray_busy", 32'(busy), 0);
    force_ready = 1'b0;

    check("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
